bool_lut_seq: RTL and testbench

Parametrised, sequential successor to the lab's fixed 3-input combinational function. An N-input Boolean function stored as a serially loaded truth table, evaluated with a registered output. A built-in sweep engine walks all 2^N input combinations, the same exhaustive pattern the lab benches apply, captures the resulting output vector, and compares it against an expected table. It sits between the lab's switch/stimulus logic and the output LEDs or checker.

---
 rtl/bool_lut_pkg.sv | 16 +
 rtl/lut_table.sv | 36 +++
 rtl/bool_lut_seq.sv | 111 +++++++++++
 tb/tb_bool_lut_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bool_lut_pkg.sv
// Shared types and helpers for the sequential Boolean LUT with its built-in sweep engine.
package bool_lut_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_IN_MAX = 6;

    function automatic int depth_of(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/lut_table.sv
// Serially loaded truth-table register with a registered normal-mode read port
// and a combinational sweep read port.
module lut_table
    import bool_lut_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int DEPTH = depth_of(N_IN)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_shift,
    input  logic            i_bit,
    input  logic [N_IN-1:0] i_in,
    input  logic [N_IN-1:0] i_idx,
    output logic            o_y,
    output logic            o_idx_bit
);

    logic [DEPTH-1:0] lut_q;

    // New bits enter at the top so the first bit of a DEPTH-bit load ends at index 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lut_q <= '0;
            o_y   <= 1'b0;
        end else begin
            if (i_shift) begin
                lut_q <= {i_bit, lut_q[DEPTH-1:1]};
            end
            o_y <= lut_q[i_in];
        end
    end

    assign o_idx_bit = lut_q[i_idx];

endmodule

// File: rtl/bool_lut_seq.sv
// N-input Boolean function with serial truth-table load, registered output and an
// exhaustive self-sweep that captures f(0..DEPTH-1) and compares it to an expected table.
module bool_lut_seq
    import bool_lut_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int DEPTH = depth_of(N_IN)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_IN-1:0]  i_in,
    output logic             o_y,
    input  logic             i_cfg_valid,
    input  logic             i_cfg_bit,
    output logic             o_cfg_done,
    input  logic             i_sweep_start,
    input  logic [DEPTH-1:0] i_exp,
    output logic             o_sweep_busy,
    output logic [N_IN-1:0]  o_sweep_in,
    output logic [DEPTH-1:0] o_sweep_vec,
    output logic             o_sweep_done,
    output logic             o_sweep_match
);

    localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

    state_t           state_q, state_d;
    logic [N_IN-1:0]  cfg_cnt_q;
    logic [N_IN-1:0]  sweep_cnt_q;
    logic [DEPTH-1:0] vec_q, vec_next, exp_q;
    logic             match_q, cfg_done_q;
    logic             shift_en, start_en, capture_en, sweep_bit;

    lut_table #(.N_IN(N_IN), .DEPTH(DEPTH)) u_table (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_shift   (shift_en),
        .i_bit     (i_cfg_bit),
        .i_in      (i_in),
        .i_idx     (sweep_cnt_q),
        .o_y       (o_y),
        .o_idx_bit (sweep_bit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Start has priority over a same-cycle cfg bit; the table is frozen outside IDLE.
    always_comb begin
        state_d    = state_q;
        shift_en   = 1'b0;
        start_en   = 1'b0;
        capture_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_sweep_start) begin
                    start_en = 1'b1;
                    state_d  = SWEEP;
                end else begin
                    shift_en = i_cfg_valid;
                end
            end
            SWEEP: begin
                capture_en = 1'b1;
                if (sweep_cnt_q == LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_next              = vec_q;
        vec_next[sweep_cnt_q] = sweep_bit;
    end

    // Match is computed from the vector including the final capture so it is ready in DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cfg_cnt_q   <= '0;
            cfg_done_q  <= 1'b0;
            sweep_cnt_q <= '0;
            vec_q       <= '0;
            exp_q       <= '0;
            match_q     <= 1'b0;
        end else begin
            cfg_done_q <= shift_en && (cfg_cnt_q == LAST);
            if (shift_en) cfg_cnt_q <= cfg_cnt_q + 1'b1;
            if (start_en) begin
                sweep_cnt_q <= '0;
                vec_q       <= '0;
                match_q     <= 1'b0;
                exp_q       <= i_exp;
            end else if (capture_en) begin
                vec_q       <= vec_next;
                sweep_cnt_q <= sweep_cnt_q + 1'b1;
                if (sweep_cnt_q == LAST) match_q <= (vec_next == exp_q);
            end
        end
    end

    assign o_cfg_done    = cfg_done_q;
    assign o_sweep_busy  = (state_q == SWEEP);
    assign o_sweep_done  = (state_q == DONE);
    assign o_sweep_in    = sweep_cnt_q;
    assign o_sweep_vec   = vec_q;
    assign o_sweep_match = match_q;

endmodule

// File: tb/tb_bool_lut_seq.sv
// Directed bench for bool_lut_seq with N_IN = 3: load, read, sweep, interference and reset cases.
module tb_bool_lut_seq;

    localparam int N = 3;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_v;
    logic         y;
    logic         cfg_valid, cfg_bit, cfg_done;
    logic         sweep_start;
    logic [D-1:0] exp_v;
    logic         busy;
    logic [N-1:0] sweep_in;
    logic [D-1:0] vec;
    logic         done, match;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    bool_lut_seq #(.N_IN(N)) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in          (in_v),
        .o_y           (y),
        .i_cfg_valid   (cfg_valid),
        .i_cfg_bit     (cfg_bit),
        .o_cfg_done    (cfg_done),
        .i_sweep_start (sweep_start),
        .i_exp         (exp_v),
        .o_sweep_busy  (busy),
        .o_sweep_in    (sweep_in),
        .o_sweep_vec   (vec),
        .o_sweep_done  (done),
        .o_sweep_match (match)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends nbits of v LSB-first, then one idle cycle; counts cfg_done pulses seen.
    task automatic load_bits(input logic [7:0] v, input int nbits, output int pulses);
        pulses = 0;
        for (int i = 0; i < nbits; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = v[i];
            tick();
            if (cfg_done) pulses++;
        end
        cfg_valid = 1'b0;
        tick();
        if (cfg_done) pulses++;
    endtask

    // cfg_mode: 0 none, 1 cfg_valid held through the whole sweep and DONE, 2 only in the start cycle.
    task automatic run_sweep(input string tag, input logic [7:0] e, input int cfg_mode,
                             input logic [7:0] want_vec, input logic want_match);
        int busy_cnt, seq_err, cd_seen;
        busy_cnt = 0; seq_err = 0; cd_seen = 0;
        exp_v       = e;
        sweep_start = 1'b1;
        cfg_valid   = (cfg_mode != 0);
        cfg_bit     = 1'b1;
        tick();
        sweep_start = 1'b0;
        if (cfg_mode == 2) cfg_valid = 1'b0;
        exp_v = ~e;
        for (int k = 0; k < D; k++) begin
            if (busy) busy_cnt++;
            if (sweep_in != N'(k)) seq_err++;
            if (cfg_done) cd_seen++;
            tick();
        end
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_index_seq_err"}, seq_err, 0);
        check({tag, "_busy_low_in_done"}, busy, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_vec"}, vec, want_vec);
        check({tag, "_match"}, match, want_match);
        tick();
        cfg_valid = 1'b0;
        if (cfg_done) cd_seen++;
        check({tag, "_cfg_done_seen"}, cd_seen, 0);
        check({tag, "_done_pulse_end"}, done, 0);
        check({tag, "_vec_hold"}, vec, want_vec);
        check({tag, "_match_hold"}, match, want_match);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; in_v = '0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        sweep_start = 1'b0; exp_v = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec", vec, 0);
        check("rst_match", match, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_sweep_in", sweep_in, 0);

        // XOR3 truth table 0x96
        load_bits(8'h96, 8, pulses);
        check("xor_cfg_done_pulses", pulses, 1);
        in_v = 3'd7; tick();
        check("xor_y_in7", y, 1);
        in_v = 3'd3; tick();
        check("xor_y_in3", y, 0);
        run_sweep("xor", 8'h96, 0, 8'h96, 1'b1);

        // majority 0xE8 against the XOR expectation
        load_bits(8'hE8, 8, pulses);
        check("maj_cfg_done_pulses", pulses, 1);
        in_v = 3'd3; tick();
        check("maj_y_in3", y, 1);
        in_v = 3'd4; tick();
        check("maj_y_in4", y, 0);
        run_sweep("maj", 8'h96, 0, 8'hE8, 1'b0);

        // cfg_valid held high across a whole sweep must not disturb the table
        load_bits(8'h96, 8, pulses);
        run_sweep("frz", 8'h96, 1, 8'h96, 1'b1);
        check("frz_table", u_dut.u_table.lut_q, 8'h96);
        check("frz_cfg_cnt", u_dut.cfg_cnt_q, 0);

        // partial load of 1,0,1 onto 0x96 gives 0xB2 and cfg count 3
        load_bits(8'h05, 3, pulses);
        check("part_cfg_done_pulses", pulses, 0);
        check("part_cfg_cnt", u_dut.cfg_cnt_q, 3);
        run_sweep("same", 8'hB2, 2, 8'hB2, 1'b1);
        check("same_cfg_cnt", u_dut.cfg_cnt_q, 3);
        check("same_table", u_dut.u_table.lut_q, 8'hB2);

        // reset in the 4th sweep cycle
        load_bits(8'hE8, 8, pulses);
        exp_v = 8'hE8; sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick(); tick(); tick();
        check("mid_sweep_in", sweep_in, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_state", u_dut.state_q, 0);
        check("mrst_busy", busy, 0);
        check("mrst_vec", vec, 0);
        check("mrst_table", u_dut.u_table.lut_q, 0);
        check("mrst_y", y, 0);
        check("mrst_match", match, 0);
        check("mrst_cfg_cnt", u_dut.cfg_cnt_q, 0);
        load_bits(8'hE8, 8, pulses);
        check("post_cfg_done_pulses", pulses, 1);
        run_sweep("post", 8'hE8, 0, 8'hE8, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
